// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the SimpleRISC fetch-side sequencer.
// Imported by the sequencer top and its counter sub-module.
package simplerisc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_e;

    localparam word_t PC_STEP          = 32'd4;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t COUNT_MAX        = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// 32-bit saturating event counter with enable and synchronous reset.
// Sticks at all-ones instead of wrapping.
module sat_counter
    import simplerisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output word_t count
);

    word_t cnt_d;
    word_t cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != COUNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// SimpleRISC fetch sequencer: PC, E/GT flags, flush/stall control
// around branches, data locks and hlt, plus saturating perf counters.
module pc_sequencer
    import simplerisc_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  isBranchTaken,
    input  word_t branchPC,
    input  logic  isDataLock,
    input  logic  isCmp,
    input  logic  cmpE,
    input  logic  cmpGT,
    input  logic  isHalt,
    output word_t pc,
    output logic  fetchEn,
    output logic  stallIF,
    output logic  flushIF,
    output logic  flushOF,
    output logic  flagE,
    output logic  flagGT,
    output logic  halted,
    output word_t cycleCount,
    output word_t branchCount,
    output word_t stallCount
);

    seq_state_e state_d, state_q;
    word_t      pc_d, pc_q;
    logic       flag_e_d, flag_e_q;
    logic       flag_gt_d, flag_gt_q;

    logic run;
    logic halt_go;
    logic branch_go;
    logic lock_go;

    // Priority: halt > taken branch > data lock > sequential.
    assign run       = (state_q == RUN);
    assign halt_go   = run && isHalt;
    assign branch_go = run && !isHalt && isBranchTaken;
    assign lock_go   = run && !isHalt && !isBranchTaken && isDataLock;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flag_e_d  = flag_e_q;
        flag_gt_d = flag_gt_q;
        fetchEn   = run;
        stallIF   = lock_go;
        flushIF   = halt_go || branch_go;
        flushOF   = halt_go || branch_go;

        unique case (1'b1)
            !run:      pc_d = pc_q;
            halt_go:   state_d = HALT;
            branch_go: pc_d = branchPC;
            lock_go:   pc_d = pc_q;
            default:   pc_d = pc_q + PC_STEP;
        endcase

        if (run && isCmp) begin
            flag_e_d  = cmpE;
            flag_gt_d = cmpGT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
        end
    end

    sat_counter u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .count (cycleCount)
    );

    sat_counter u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (branch_go),
        .count (branchCount)
    );

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (lock_go),
        .count (stallCount)
    );

    assign pc     = pc_q;
    assign flagE  = flag_e_q;
    assign flagGT = flag_gt_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a
// randomized run against a behavioural model of the sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        isBranchTaken;
    logic [31:0] branchPC;
    logic        isDataLock;
    logic        isCmp;
    logic        cmpE;
    logic        cmpGT;
    logic        isHalt;
    logic [31:0] pc;
    logic        fetchEn;
    logic        stallIF;
    logic        flushIF;
    logic        flushOF;
    logic        flagE;
    logic        flagGT;
    logic        halted;
    logic [31:0] cycleCount;
    logic [31:0] branchCount;
    logic [31:0] stallCount;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_e, m_gt, m_halted;
    logic [31:0] m_cyc, m_br, m_stall;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .isBranchTaken (isBranchTaken),
        .branchPC      (branchPC),
        .isDataLock    (isDataLock),
        .isCmp         (isCmp),
        .cmpE          (cmpE),
        .cmpGT         (cmpGT),
        .isHalt        (isHalt),
        .pc            (pc),
        .fetchEn       (fetchEn),
        .stallIF       (stallIF),
        .flushIF       (flushIF),
        .flushOF       (flushOF),
        .flagE         (flagE),
        .flagGT        (flagGT),
        .halted        (halted),
        .cycleCount    (cycleCount),
        .branchCount   (branchCount),
        .stallCount    (stallCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic drive(input logic h, input logic b, input logic [31:0] t,
                         input logic l, input logic c, input logic e,
                         input logic g);
        isHalt = h; isBranchTaken = b; branchPC = t;
        isDataLock = l; isCmp = c; cmpE = e; cmpGT = g;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Apply the sequencer rules to the model, then clock the DUT.
    task automatic tick();
        if (rst) begin
            m_pc = 32'h0; m_e = 0; m_gt = 0; m_halted = 0;
            m_cyc = 0; m_br = 0; m_stall = 0;
        end else if (!m_halted) begin
            m_cyc = sat_inc(m_cyc);
            if (isCmp) begin
                m_e = cmpE; m_gt = cmpGT;
            end
            if (isHalt) begin
                m_halted = 1;
            end else if (isBranchTaken) begin
                m_pc = branchPC;
                m_br = sat_inc(m_br);
            end else if (isDataLock) begin
                m_stall = sat_inc(m_stall);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; idle(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || flagE !== 0 || flagGT !== 0 || halted !== 0) begin
            n_bad++;
            $display("FAIL reset_regs: pc=%h E=%b GT=%b halted=%b want 0", pc, flagE, flagGT, halted);
        end
        n_cmp++;
        if (cycleCount !== 0 || branchCount !== 0 || stallCount !== 0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h %h %h want 0", cycleCount, branchCount, stallCount);
        end
        n_cmp++;
        if ({fetchEn, stallIF, flushIF, flushOF} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_comb: got %b want 1000", {fetchEn, stallIF, flushIF, flushOF});
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (pc !== 32'(4 * i)) begin
                n_bad++;
                $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i));
            end
        end
        n_cmp++;
        if (cycleCount !== 32'd4) begin
            n_bad++;
            $display("FAIL seq_cycles: got %0d want 4", cycleCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        tick(); tick();
        drive(0, 1, 32'h100, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (pc !== 32'h8 || flushIF !== 1 || flushOF !== 1) begin
            n_bad++;
            $display("FAIL br_flush: pc=%h fIF=%b fOF=%b want 8,1,1", pc, flushIF, flushOF);
        end
        tick(); idle();
        n_cmp++;
        if (pc !== 32'h100 || branchCount !== 32'd1) begin
            n_bad++;
            $display("FAIL br_target: pc=%h cnt=%0d want 100,1", pc, branchCount);
        end
    endtask

    task automatic test_data_lock();
        do_reset();
        drive(0, 1, 32'h20, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0);
            #1;
            n_cmp++;
            if (stallIF !== 1 || flushIF !== 0) begin
                n_bad++;
                $display("FAIL lock_stall%0d: stall=%b flush=%b want 1,0", i, stallIF, flushIF);
            end
            tick();
            n_cmp++;
            if (pc !== 32'h20) begin
                n_bad++;
                $display("FAIL lock_pc%0d: got %h want 20", i, pc);
            end
        end
        n_cmp++;
        if (stallCount !== 32'd3) begin
            n_bad++;
            $display("FAIL lock_count: got %0d want 3", stallCount);
        end
        drive(0, 1, 32'h40, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (stallIF !== 0 || flushIF !== 1) begin
            n_bad++;
            $display("FAIL lock_br_stall: stall=%b flush=%b want 0,1", stallIF, flushIF);
        end
        tick(); idle();
        n_cmp++;
        if (pc !== 32'h40 || stallCount !== 32'd3) begin
            n_bad++;
            $display("FAIL lock_br_pc: pc=%h stalls=%0d want 40,3", pc, stallCount);
        end
    endtask

    task automatic test_flags_halt();
        logic [31:0] frozen;
        do_reset();
        tick();
        drive(0, 0, 32'h0, 0, 1, 1, 0); tick(); idle();
        n_cmp++;
        if (flagE !== 1 || flagGT !== 0) begin
            n_bad++;
            $display("FAIL cmp_flags: E=%b GT=%b want 1,0", flagE, flagGT);
        end
        drive(1, 0, 32'h0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (flushIF !== 1 || flushOF !== 1) begin
            n_bad++;
            $display("FAIL halt_flush: %b%b want 11", flushIF, flushOF);
        end
        frozen = pc;
        tick();
        drive(0, 1, 32'h500, 1, 1, 0, 1);
        #1;
        n_cmp++;
        if (halted !== 1 || fetchEn !== 0 || stallIF !== 0 || flushIF !== 0 || flushOF !== 0) begin
            n_bad++;
            $display("FAIL halt_outs: h=%b fe=%b st=%b f=%b%b want 1,0,0,00",
                     halted, fetchEn, stallIF, flushIF, flushOF);
        end
        tick(); tick(); idle();
        n_cmp++;
        if (pc !== frozen || flagE !== 1 || flagGT !== 0 || branchCount !== 0 || cycleCount !== 32'd3) begin
            n_bad++;
            $display("FAIL halt_frozen: pc=%h E=%b GT=%b br=%0d cyc=%0d want %h,1,0,0,3",
                     pc, flagE, flagGT, branchCount, cycleCount, frozen);
        end
        do_reset();
        n_cmp++;
        if (pc !== 32'h0 || flagE !== 0 || halted !== 0 || fetchEn !== 1) begin
            n_bad++;
            $display("FAIL halt_reset: pc=%h E=%b h=%b fe=%b want 0,0,0,1", pc, flagE, halted, fetchEn);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick(); idle();
        tick();
        n_cmp++;
        if (pc !== 32'h0) begin
            n_bad++;
            $display("FAIL pc_wrap: got %h want 0", pc);
        end
        drive(0, 1, 32'h0000_0123, 0, 0, 0, 0); tick(); idle();
        n_cmp++;
        if (pc !== 32'h123) begin
            n_bad++;
            $display("FAIL unaligned: got %h want 123", pc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        drive(0, 1, 32'hA00, 0, 0, 0, 0); tick();
        n_cmp++;
        if (pc !== 32'hA00) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want a00", pc);
        end
        drive(0, 1, 32'hB00, 0, 0, 0, 0); tick(); idle();
        n_cmp++;
        if (pc !== 32'hB00 || branchCount !== 32'd2) begin
            n_bad++;
            $display("FAIL b2b_second: pc=%h cnt=%0d want b00,2", pc, branchCount);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFD;
        force dut.u_branch_cnt.cnt_q = 32'hFFFF_FFFE;
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_cycle_cnt.cnt_q;
        release dut.u_branch_cnt.cnt_q;
        release dut.u_stall_cnt.cnt_q;
        m_cyc = 32'hFFFF_FFFD; m_br = 32'hFFFF_FFFE; m_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h40, 0, 0, 0, 0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0); tick();
        end
        idle();
        n_cmp++;
        if (cycleCount !== 32'hFFFF_FFFF || branchCount !== 32'hFFFF_FFFF || stallCount !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL saturate: got %h %h %h want ffffffff", cycleCount, branchCount, stallCount);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 20, $urandom,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
                  1'($urandom), 1'($urandom));
            #1;
            n_cmp++;
            if (fetchEn !== !m_halted
                || flushIF !== (!m_halted && (isHalt || isBranchTaken))
                || flushOF !== flushIF
                || stallIF !== (!m_halted && !isHalt && !isBranchTaken && isDataLock)) begin
                n_bad++;
                $display("FAIL rnd_comb%0d: fe=%b st=%b f=%b%b halted_model=%b", i,
                         fetchEn, stallIF, flushIF, flushOF, m_halted);
            end
            tick();
            n_cmp++;
            if (pc !== m_pc || flagE !== m_e || flagGT !== m_gt || halted !== m_halted
                || cycleCount !== m_cyc || branchCount !== m_br || stallCount !== m_stall) begin
                n_bad++;
                $display("FAIL rnd_regs%0d: pc=%h/%h E=%b/%b GT=%b/%b h=%b/%b c=%0d/%0d b=%0d/%0d s=%0d/%0d",
                         i, pc, m_pc, flagE, m_e, flagGT, m_gt, halted, m_halted,
                         cycleCount, m_cyc, branchCount, m_br, stallCount, m_stall);
            end
            if (m_halted && $urandom_range(0, 9) == 0) begin
                rst = 1;
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_data_lock();
        test_flags_halt();
        test_wrap();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
